// File: rtl/answer_period_timer.sv
// Answer-window timer: opens a timed window on an answerSig edge, resolves
// first-to-buzz or timeout, pulses postSig/stopCount and drives four 7-seg digits.
module answer_period_timer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PERIOD_SEC  = 5,
  parameter int NUM_PLAYERS = 4
) (
  input  logic                   Clk100M,
  input  logic                   Rst_n,
  input  logic                   answerSig,
  input  logic                   abortSig,
  input  logic [NUM_PLAYERS-1:0] buzz,
  output logic                   postSig,
  output logic                   stopCount,
  output logic                   running,
  output logic                   timedOut,
  output logic                   winnerValid,
  output logic [3:0]             winner,
  output logic [7:0]             answerSeg0,
  output logic [7:0]             answerSeg1,
  output logic [7:0]             answerSeg2,
  output logic [7:0]             answerSeg3,
  output logic [1:0]             state_dbg
);

  localparam int DW = $clog2(CLK_FREQ_HZ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [DW-1:0] divider;
  logic [6:0]    remaining;
  logic          ans_q;
  logic          tick;
  logic          buzz_any;
  logic [3:0]    buzz_idx;
  logic [3:0]    tens_d;
  logic [3:0]    ones_d;

  assign state_dbg = state;
  assign tick      = (divider == DW'(CLK_FREQ_HZ - 1));
  assign buzz_any  = |buzz;

  // Lowest-index player wins; scan from the top so the lowest set bit lands last.
  always_comb begin
    buzz_idx = 4'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (buzz[i]) buzz_idx = 4'(i + 1);
    end
  end

  always_comb begin
    tens_d = 4'(remaining / 7'd10);
    ones_d = 4'(remaining % 7'd10);
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      divider     <= '0;
      remaining   <= 7'd0;
      ans_q       <= 1'b0;
      postSig     <= 1'b0;
      stopCount   <= 1'b0;
      running     <= 1'b0;
      timedOut    <= 1'b0;
      winnerValid <= 1'b0;
      winner      <= 4'd0;
    end else begin
      ans_q     <= answerSig;
      postSig   <= 1'b0;
      stopCount <= 1'b0;
      case (state)
        IDLE: begin
          if (answerSig && !ans_q) begin
            state       <= RUN;
            running     <= 1'b1;
            remaining   <= 7'(PERIOD_SEC);
            divider     <= '0;
            timedOut    <= 1'b0;
            winnerValid <= 1'b0;
            winner      <= 4'd0;
          end
        end
        RUN: begin
          // Abort outranks a buzz in the same cycle; a buzz outranks the tick.
          if (abortSig) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (buzz_any) begin
            state       <= DONE;
            running     <= 1'b0;
            winner      <= buzz_idx;
            winnerValid <= 1'b1;
            postSig     <= 1'b1;
            stopCount   <= 1'b1;
          end else if (tick) begin
            divider <= '0;
            if (remaining == 7'd1) begin
              remaining <= 7'd0;
              timedOut  <= 1'b1;
              state     <= DONE;
              running   <= 1'b0;
              postSig   <= 1'b1;
              stopCount <= 1'b1;
            end else begin
              remaining <= remaining - 7'd1;
            end
          end else begin
            divider <= divider + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      answerSeg0 <= 8'hC0;
      answerSeg1 <= 8'hFF;
      answerSeg2 <= 8'hFF;
      answerSeg3 <= 8'hFF;
    end else begin
      answerSeg0 <= seg7(ones_d);
      answerSeg1 <= (tens_d == 4'd0) ? 8'hFF : seg7(tens_d);
      answerSeg2 <= winnerValid ? seg7(winner) : 8'hFF;
      if (state == RUN)     answerSeg3 <= 8'h88;
      else if (winnerValid) answerSeg3 <= 8'h8C;
      else if (timedOut)    answerSeg3 <= 8'h86;
      else                  answerSeg3 <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_answer_period_timer.sv
// Bench for answer_period_timer: directed and random windows scored against an
// arithmetic window-outcome model; a second instance covers two-digit periods.
module tb_answer_period_timer;
  localparam int C  = 4;
  localparam int P  = 3;
  localparam int NP = 4;
  localparam int T  = C * P;

  // ---------------- clock / reset ----------------
  logic Clk100M = 1'b0;
  logic Rst_n   = 1'b0;
  always #5 Clk100M = ~Clk100M;

  logic          answerSig = 1'b0;
  logic          abortSig  = 1'b0;
  logic [NP-1:0] buzz      = '0;
  logic          postSig, stopCount, running, timedOut, winnerValid;
  logic [3:0]    winner;
  logic [7:0]    answerSeg0, answerSeg1, answerSeg2, answerSeg3;
  logic [1:0]    state_dbg;

  logic       answerSig2 = 1'b0;
  logic [0:0] buzz2      = 1'b0;
  logic       postSig2, stopCount2, running2, timedOut2, winnerValid2;
  logic [3:0] winner2;
  logic [7:0] seg2_0, seg2_1, seg2_2, seg2_3;
  logic [1:0] state_dbg2;

  answer_period_timer #(.CLK_FREQ_HZ(C), .PERIOD_SEC(P), .NUM_PLAYERS(NP)) u_dut (
    .Clk100M(Clk100M), .Rst_n(Rst_n), .answerSig(answerSig), .abortSig(abortSig),
    .buzz(buzz), .postSig(postSig), .stopCount(stopCount), .running(running),
    .timedOut(timedOut), .winnerValid(winnerValid), .winner(winner),
    .answerSeg0(answerSeg0), .answerSeg1(answerSeg1), .answerSeg2(answerSeg2),
    .answerSeg3(answerSeg3), .state_dbg(state_dbg)
  );

  answer_period_timer #(.CLK_FREQ_HZ(2), .PERIOD_SEC(12), .NUM_PLAYERS(1)) u_dut12 (
    .Clk100M(Clk100M), .Rst_n(Rst_n), .answerSig(answerSig2), .abortSig(1'b0),
    .buzz(buzz2), .postSig(postSig2), .stopCount(stopCount2), .running(running2),
    .timedOut(timedOut2), .winnerValid(winnerValid2), .winner(winner2),
    .answerSeg0(seg2_0), .answerSeg1(seg2_1), .answerSeg2(seg2_2),
    .answerSeg3(seg2_3), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // Expected window outcome: {timedOut, winnerValid, winner[3:0], remaining[6:0]}
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  function automatic int lowest_player(input logic [NP-1:0] pat);
    for (int i = 0; i < NP; i++) if (pat[i]) return i + 1;
    return 0;
  endfunction

  // ---------------- driver ----------------
  // kind: 0 timeout, 1 buzz at RUN offset 'at', 2 abort at RUN offset 'at'.
  task automatic run_window(input int kind, input int at, input logic [NP-1:0] pat,
                            input bit hold);
    int          end_off;
    int          rem;
    int          win;
    logic [12:0] exp;
    logic [12:0] got_exp;
    end_off = (kind == 0) ? T - 1 : at;
    rem     = (kind == 0) ? 0 : P - at / C;
    win     = (kind == 1) ? lowest_player(pat) : 0;
    exp     = {(kind == 0), (kind == 1), 4'(win), 7'(rem)};
    exp_q.push_back(exp);

    @(negedge Clk100M);
    answerSig = 1'b1;
    for (int k = 0; k <= end_off + 1; k++) begin
      @(negedge Clk100M);
      check_eq("running", running, (k <= end_off));
      check_eq("postSig", postSig, (k == end_off + 1) && (kind != 2));
      check_eq("stopCount", stopCount, (k == end_off + 1) && (kind != 2));
      if (k >= 1) begin
        check_eq("seg0_run", answerSeg0, seg_of((P - (k - 1) / C) % 10));
        check_eq("seg3_run", answerSeg3, 8'h88);
        check_eq("seg2_run", answerSeg2, 8'hFF);
      end
      if (k == end_off + 1) begin
        got_exp = exp_q.pop_front();
        check_eq("timedOut", timedOut, got_exp[12]);
        check_eq("winnerValid", winnerValid, got_exp[11]);
        check_eq("winner", winner, got_exp[10:7]);
      end
      if (!hold) answerSig = 1'b0;
      buzz     = (kind == 1 && k == at) ? pat :
                 (k == end_off + 1) ? NP'($urandom_range(0, 15)) : '0;
      abortSig = (kind == 2 && k == at) || (k == end_off + 1 && $urandom_range(0, 1) == 1);
    end
    // Tail: window closed, buzz/abort noise must be ignored and a held answerSig must not retrigger.
    for (int t = 0; t < 2; t++) begin
      @(negedge Clk100M);
      check_eq("running_tail", running, 0);
      check_eq("postSig_tail", postSig, 0);
      buzz     = NP'($urandom_range(0, 15));
      abortSig = 1'($urandom_range(0, 1));
    end
    check_eq("seg0_end", answerSeg0, seg_of(rem % 10));
    check_eq("seg1_end", answerSeg1, (rem / 10 == 0) ? 8'hFF : seg_of(rem / 10));
    check_eq("seg2_end", answerSeg2, (kind == 1) ? seg_of(win) : 8'hFF);
    check_eq("seg3_end", answerSeg3, (kind == 1) ? 8'h8C : (kind == 0) ? 8'h86 : 8'hFF);
    answerSig = 1'b0;
    buzz      = '0;
    abortSig  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_postSig"}, postSig, 0);
    check_eq({tag, "_stopCount"}, stopCount, 0);
    check_eq({tag, "_running"}, running, 0);
    check_eq({tag, "_timedOut"}, timedOut, 0);
    check_eq({tag, "_winnerValid"}, winnerValid, 0);
    check_eq({tag, "_winner"}, winner, 0);
    check_eq({tag, "_seg0"}, answerSeg0, 8'hC0);
    check_eq({tag, "_seg1"}, answerSeg1, 8'hFF);
    check_eq({tag, "_seg2"}, answerSeg2, 8'hFF);
    check_eq({tag, "_seg3"}, answerSeg3, 8'hFF);
    check_eq({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check_reset_values("rst");
    @(negedge Clk100M);
    Rst_n = 1'b1;
    @(negedge Clk100M);
    check_reset_values("idle");

    // Two-digit period on the second instance.
    answerSig2 = 1'b1;
    @(negedge Clk100M);
    check_eq("p12_running", running2, 1);
    answerSig2 = 1'b0;
    @(negedge Clk100M);
    check_eq("p12_seg1", seg2_1, 8'hF9);
    check_eq("p12_seg0", seg2_0, 8'hA4);

    run_window(0, 0, '0, 1'b0);             // plain timeout
    run_window(1, 5, 4'b0100, 1'b0);        // player 3 buzzes, remaining frozen at 2
    run_window(1, T - 1, 4'b1010, 1'b0);    // buzz on the final tick wins
    run_window(2, 6, '0, 1'b0);             // abort, then restart below
    run_window(0, 0, '0, 1'b1);             // answerSig held across window and DONE
    run_window(1, 0, 4'b1000, 1'b0);        // buzz in the very first RUN cycle

    for (int n = 0; n < 30; n++) begin
      int          kind;
      logic [NP-1:0] pat;
      kind = $urandom_range(0, 2);
      pat  = NP'($urandom_range(1, 15));
      run_window(kind, $urandom_range(0, T - 1), pat, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a window.
    @(negedge Clk100M);
    answerSig = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge Clk100M);
    check_eq("pre_rst_running", running, 1);
    #2 Rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge Clk100M);
    Rst_n     = 1'b1;
    answerSig = 1'b0;
    for (int k = 0; k < T + 4; k++) begin
      @(negedge Clk100M);
      check_eq("post_rst_running", running, 0);
      check_eq("post_rst_postSig", postSig, 0);
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
